rangefinder_sample_capture: RTL and testbench

Capture engine driving the write side (port s2: `address2`/`chipselect2`/`write2`/`writedata2`) of the rangefinder 256×8 sample RAM. Once armed by the CPU, it waits for a rising edge on the asynchronous echo trigger. It then streams a programmable number of ADC samples into consecutive RAM locations starting at address 0, and raises `done` plus a one-cycle `irq`. The CPU reads the samples back through port s1.

---
 rtl/rangefinder_sample_capture_pkg.sv | 18 +
 rtl/rangefinder_sample_capture_if.sv | 30 +++
 rtl/rangefinder_sample_capture_trigger_sync.sv | 38 +++
 rtl/rangefinder_sample_capture.sv | 193 +++++++++++++++++++
 tb/tb_rangefinder_sample_capture.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rangefinder_sample_capture_pkg.sv
// rangefinder_capture_pkg
// Shared types and defaults for the rangefinder sample-capture engine:
//   capture_state_t : capture FSM state encoding
//   CAP_ADDR_W      : default sample RAM address width (depth 256)
//   CAP_DATA_W      : default sample width
package rangefinder_capture_pkg;

  localparam int CAP_ADDR_W = 8;
  localparam int CAP_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

endpackage

// File: rtl/rangefinder_sample_capture_if.sv
// rangefinder_sample_capture_if
// Write-side bus of the sample RAM (port s2).
//   ram_address    : address2
//   ram_chipselect : chipselect2
//   ram_write      : write2
//   ram_writedata  : writedata2
//   ram_clken      : clken2
// master = capture engine, slave = RAM.
interface rangefinder_sample_capture_if
  import rangefinder_capture_pkg::*;
#(
  parameter int ADDR_W = CAP_ADDR_W,
  parameter int DATA_W = CAP_DATA_W
);

  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;

  modport master (
    output ram_address, ram_chipselect, ram_write, ram_writedata, ram_clken
  );

  modport slave (
    input ram_address, ram_chipselect, ram_write, ram_writedata, ram_clken
  );

endinterface

// File: rtl/rangefinder_sample_capture_trigger_sync.sv
// rangefinder_trigger_sync
// Brings the asynchronous echo comparator output into the clk domain and
// flags its rising edges.
//   clk, reset  : block clock, asynchronous active-high reset
//   trigger_in  : asynchronous comparator level
//   trig_rise   : one-cycle pulse per synchronized low->high transition
module rangefinder_trigger_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger_in,
  output logic trig_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values: shift the raw level in, remember the last synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], trigger_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer chain and edge-detect flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign trig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rangefinder_sample_capture.sv
// rangefinder_sample_capture
// Arms on a CPU pulse, waits for a rising echo trigger, then streams
// capture_len+1 ADC samples into the sample RAM from address 0 upward and
// raises a sticky done flag plus a one-cycle irq.
//   clk, reset       : block clock, asynchronous active-high reset
//   arm / abort      : one-cycle CPU control pulses (abort has priority)
//   capture_len      : samples minus one, latched on arm
//   decim            : keep 1 of decim+1 valid samples (decimation build only)
//   trigger_in       : asynchronous echo comparator output
//   adc_data/valid   : sample stream
//   ram              : registered RAM write port (interface, master side)
//   busy/done/irq    : status; count = samples written this/last capture
// Optional feature: define RANGEFINDER_CAPTURE_DECIM_EN to enable decimation;
// without it, decim is ignored and every valid sample in CAPTURE is written.
module rangefinder_sample_capture
  import rangefinder_capture_pkg::*;
#(
  parameter int ADDR_W      = CAP_ADDR_W,
  parameter int DATA_W      = CAP_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     capture_len,
  input  logic [3:0]            decim,
  input  logic                  trigger_in,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  rangefinder_sample_capture_if.master ram,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic [ADDR_W:0]       count
);

  capture_state_t    state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              trig_rise_s;
  logic              sample_ok_s;
  logic              last_s;

  rangefinder_trigger_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trigger_sync (
    .clk        (clk),
    .reset      (reset),
    .trigger_in (trigger_in),
    .trig_rise  (trig_rise_s)
  );

`ifdef RANGEFINDER_CAPTURE_DECIM_EN
  logic [3:0] dcnt_q, dcnt_d;

  // Decimation phase: held at 0 outside CAPTURE so the first sample in
  // CAPTURE is always kept; wraps after decim skipped samples.
  always_comb begin
    if (state_q != CAPTURE) begin
      dcnt_d = 4'd0;
    end else if (adc_valid) begin
      if (dcnt_q >= decim) begin
        dcnt_d = 4'd0;
      end else begin
        dcnt_d = dcnt_q + 4'd1;
      end
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // Decimation phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt_q <= 4'd0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign sample_ok_s = adc_valid & (dcnt_q == 4'd0);
`else
  logic [3:0] unused_decim_s;
  assign unused_decim_s = decim;
  assign sample_ok_s    = adc_valid;
`endif

  // FSM next state, write-port and status next values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    done_d  = done_q;
    irq_d   = 1'b0;
    count_d = count_q;
    // The write in progress is the final one when count reaches len before incrementing.
    last_s  = (count_q == {1'b0, len_q});
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = ARMED;
            len_d   = capture_len;
            done_d  = 1'b0;
            count_d = {(ADDR_W+1){1'b0}};
            ptr_d   = {ADDR_W{1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        ARMED: begin
          if (trig_rise_s) begin
            state_d = CAPTURE;
          end else begin
            state_d = ARMED;
          end
        end
        CAPTURE: begin
          if (sample_ok_s) begin
            wr_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = adc_data;
            count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
            if (last_s) begin
              // Pointer is left in place so a full-depth capture never wraps.
              state_d = DONE;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end else begin
              ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = CAPTURE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
  end

  // State and registered outputs; reset discards all capture state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= {ADDR_W{1'b0}};
      len_q   <= {ADDR_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      count_q <= count_d;
    end
  end

  assign ram.ram_address    = addr_q;
  assign ram.ram_chipselect = wr_q;
  assign ram.ram_write      = wr_q;
  assign ram.ram_writedata  = wdata_q;
  assign ram.ram_clken      = 1'b1;
  assign busy               = busy_q;
  assign done               = done_q;
  assign irq                = irq_q;
  assign count              = count_q;

endmodule

// File: tb/tb_rangefinder_sample_capture.sv
module tb_rangefinder_sample_capture;

  localparam int SYNC = 2;
`ifdef RANGEFINDER_CAPTURE_DECIM_EN
  localparam bit DECIM_EN = 1'b1;
`else
  localparam bit DECIM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic       abort;
  logic [7:0] capture_len;
  logic [3:0] decim;
  logic       trigger_in;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       busy;
  logic       done;
  logic       irq;
  logic [8:0] count;

  rangefinder_sample_capture_if #(.ADDR_W(8), .DATA_W(8)) ram_if ();

  rangefinder_sample_capture #(.ADDR_W(8), .DATA_W(8), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .abort       (abort),
    .capture_len (capture_len),
    .decim       (decim),
    .trigger_in  (trigger_in),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .ram         (ram_if),
    .busy        (busy),
    .done        (done),
    .irq         (irq),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM-side observer: every write seen, with done/irq at that moment.
  int wr_addr[$];
  int wr_data[$];
  bit wr_done[$];
  bit wr_irq[$];
  int irq_seen = 0;

  always @(negedge clk) begin
    if (ram_if.ram_write && ram_if.ram_chipselect) begin
      wr_addr.push_back(int'(ram_if.ram_address));
      wr_data.push_back(int'(ram_if.ram_writedata));
      wr_done.push_back(done);
      wr_irq.push_back(irq);
    end
    if (irq) irq_seen++;
  end

  int base;
  int irq_base;
  int exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic go_idle();
    @(negedge clk);
    abort = 1'b1; trigger_in = 1'b0; adc_valid = 1'b0; arm = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  // Arms, triggers and streams samples; the model keeps every (decim+1)th
  // valid sample from the first capturable cycle until len+1 are kept.
  task automatic do_capture(input int len, input int n_valid, input int dens,
                            input int dec, input int seq_base);
    int k; int step; logic [7:0] d; bit v;
    step = DECIM_EN ? dec + 1 : 1;
    go_idle();
    base = wr_addr.size(); irq_base = irq_seen; exp_q.delete();
    capture_len = len[7:0]; decim = dec[3:0]; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; trigger_in = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    k = 0;
    for (int i = 0; i < n_valid; i++) begin
      v = ($urandom_range(99) < dens);
      d = (seq_base >= 0) ? 8'(seq_base + i) : 8'($urandom);
      adc_valid = v; adc_data = d;
      if (v) begin
        if ((k % step) == 0 && exp_q.size() < len + 1) exp_q.push_back(int'(d));
        k++;
      end
      @(negedge clk);
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ram_if.ram_address, ram_if.ram_chipselect, ram_if.ram_write, ram_if.ram_writedata,
         busy, done, irq, count} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_values: got addr=%0h cs=%0b wr=%0b wd=%0h busy=%0b done=%0b irq=%0b count=%0d, expected all 0",
               ram_if.ram_address, ram_if.ram_chipselect, ram_if.ram_write, ram_if.ram_writedata,
               busy, done, irq, count);
    end
    n_checks++;
    if (ram_if.ram_clken !== 1'b1) begin
      n_fail++; $display("FAIL reset_clken: got %0b expected 1", ram_if.ram_clken);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 9'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%0b done=%0b count=%0d expected 0/0/0", busy, done, count);
    end
  endtask

  // Directed cases (4 samples, 1 sample, full depth) then random captures.
  task automatic test_capture();
    int len; int nv; int dens; int dec; int sb; int got; bit full;
    for (int t = 0; t < 9; t++) begin
      case (t)
        0: begin len = 3;   nv = 8;   dens = 100; sb = 8'h10; dec = 0; end
        1: begin len = 0;   nv = 4;   dens = 100; sb = 8'h80; dec = 0; end
        2: begin len = 255; nv = 300; dens = 100; sb = 0;     dec = 0; end
        default: begin
          len = $urandom_range(40); nv = $urandom_range(60, 5);
          dens = $urandom_range(100, 30); sb = -1; dec = $urandom_range(3);
        end
      endcase
      do_capture(len, nv, dens, dec, sb);
      full = (exp_q.size() == len + 1);
      got  = wr_addr.size() - base;
      n_checks++;
      if (got != exp_q.size()) begin
        n_fail++; $display("FAIL cap%0d write_count: got %0d expected %0d", t, got, exp_q.size());
      end
      for (int i = 0; i < got && i < exp_q.size(); i++) begin
        n_checks++;
        if (wr_addr[base+i] != i || wr_data[base+i] != exp_q[i]) begin
          n_fail++; $display("FAIL cap%0d write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                             t, i, wr_addr[base+i], wr_data[base+i], i, exp_q[i]);
        end
        n_checks++;
        if (wr_done[base+i] != (full && i == len) || wr_irq[base+i] != (full && i == len)) begin
          n_fail++; $display("FAIL cap%0d done_irq_at_write%0d: got done=%0b irq=%0b expected %0b",
                             t, i, wr_done[base+i], wr_irq[base+i], full && i == len);
        end
      end
      n_checks++;
      if (count !== 9'(exp_q.size()) || done !== full || busy !== !full ||
          (irq_seen - irq_base) != int'(full)) begin
        n_fail++; $display("FAIL cap%0d status: got count=%0d done=%0b busy=%0b irqs=%0d expected %0d/%0b/%0b/%0d",
                           t, count, done, busy, irq_seen - irq_base, exp_q.size(), full, !full, int'(full));
      end
    end
  endtask

  task automatic test_trigger_qual();
    int got; int d0;
    go_idle();
    decim = 4'd0; trigger_in = 1'b1;
    repeat (6) @(negedge clk);
    base = wr_addr.size(); irq_base = irq_seen;
    capture_len = 8'd3; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'b1; adc_data = 8'(i); @(negedge clk);
    end
    n_checks++;
    if (wr_addr.size() != base || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL trig_level_not_edge: got writes=%0d busy=%0b done=%0b expected 0/1/0",
                         wr_addr.size() - base, busy, done);
    end
    trigger_in = 1'b0;
    d0 = 100;
    for (int i = 0; i < SYNC + 2; i++) begin
      adc_data = 8'(d0 - SYNC - 2 + i); @(negedge clk);
    end
    for (int j = 0; j < 12; j++) begin
      trigger_in = 1'b1; adc_valid = 1'b1; adc_data = 8'(d0 + j);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    got = wr_addr.size() - base;
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL trig_edge_writes: got %0d expected 4", got);
    end
    for (int i = 0; i < got && i < 4; i++) begin
      n_checks++;
      if (wr_addr[base+i] != i || wr_data[base+i] != d0 + SYNC + 1 + i) begin
        n_fail++; $display("FAIL trig_edge_latency%0d: got addr=%0h data=%0d expected addr=%0h data=%0d",
                           i, wr_addr[base+i], wr_data[base+i], i, d0 + SYNC + 1 + i);
      end
    end
    n_checks++;
    if (done !== 1'b1 || count !== 9'd4) begin
      n_fail++; $display("FAIL trig_edge_done: got done=%0b count=%0d expected 1/4", done, count);
    end
  endtask

  task automatic test_abort();
    int got;
    go_idle();
    decim = 4'd0;
    base = wr_addr.size(); irq_base = irq_seen;
    capture_len = 8'd50; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; trigger_in = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'b1; adc_data = 8'(8'h40 + i);
      arm = (i == 4); capture_len = (i == 4) ? 8'd0 : 8'd50;
      @(negedge clk);
    end
    arm = 1'b0; capture_len = 8'd50;
    adc_data = 8'hAA; adc_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; adc_data = 8'hBB;
    repeat (3) @(negedge clk);
    adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    got = wr_addr.size() - base;
    n_checks++;
    if (got != 10) begin
      n_fail++; $display("FAIL abort_write_count: got %0d expected 10", got);
    end
    for (int i = 0; i < got && i < 10; i++) begin
      n_checks++;
      if (wr_addr[base+i] != i || wr_data[base+i] != 8'h40 + i) begin
        n_fail++; $display("FAIL abort_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                           i, wr_addr[base+i], wr_data[base+i], i, 8'h40 + i);
      end
    end
    n_checks++;
    if (count !== 9'd10 || done !== 1'b0 || busy !== 1'b0 || irq_seen != irq_base) begin
      n_fail++; $display("FAIL abort_status: got count=%0d done=%0b busy=%0b irqs=%0d expected 10/0/0/0",
                         count, done, busy, irq_seen - irq_base);
    end
    trigger_in = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    trigger_in = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    adc_valid = 1'b1;
    repeat (4) @(negedge clk);
    adc_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_addr.size() - base != 10 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_ignores_trigger: got writes=%0d busy=%0b expected 10/0",
                         wr_addr.size() - base, busy);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    go_idle();
    decim = 4'd0;
    capture_len = 8'd100; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; trigger_in = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1; adc_data = 8'(8'h30 + i); @(negedge clk);
    end
    adc_valid = 1'b0; reset = 1'b1;
    #1;
    n_checks++;
    if ({ram_if.ram_address, ram_if.ram_chipselect, ram_if.ram_write, ram_if.ram_writedata,
         busy, done, irq, count} !== 30'd0) begin
      n_fail++; $display("FAIL async_reset: got addr=%0h cs=%0b wr=%0b wd=%0h busy=%0b done=%0b irq=%0b count=%0d, expected all 0",
                         ram_if.ram_address, ram_if.ram_chipselect, ram_if.ram_write, ram_if.ram_writedata,
                         busy, done, irq, count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_capture(3, 6, 100, 0, 8'h20);
    got = wr_addr.size() - base;
    n_checks++;
    if (got != 4) begin
      n_fail++; $display("FAIL rearm_write_count: got %0d expected 4", got);
    end
    for (int i = 0; i < got && i < 4; i++) begin
      n_checks++;
      if (wr_addr[base+i] != i || wr_data[base+i] != 8'h20 + i) begin
        n_fail++; $display("FAIL rearm_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                           i, wr_addr[base+i], wr_data[base+i], i, 8'h20 + i);
      end
    end
  endtask

`ifdef RANGEFINDER_CAPTURE_DECIM_EN
  task automatic test_decim();
    int got;
    do_capture(2, 9, 100, 2, 0);
    got = wr_addr.size() - base;
    n_checks++;
    if (got != 3) begin
      n_fail++; $display("FAIL decim_write_count: got %0d expected 3", got);
    end
    for (int i = 0; i < got && i < 3; i++) begin
      n_checks++;
      if (wr_addr[base+i] != i || wr_data[base+i] != 3 * i) begin
        n_fail++; $display("FAIL decim_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                           i, wr_addr[base+i], wr_data[base+i], i, 3 * i);
      end
    end
    n_checks++;
    if (done !== 1'b1 || count !== 9'd3) begin
      n_fail++; $display("FAIL decim_done: got done=%0b count=%0d expected 1/3", done, count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; capture_len = 8'd0; decim = 4'd0;
    trigger_in = 1'b0; adc_data = 8'd0; adc_valid = 1'b0;
    test_reset();
    test_capture();
    test_trigger_qual();
    test_abort();
    test_reset_mid();
`ifdef RANGEFINDER_CAPTURE_DECIM_EN
    test_decim();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
